// File: rtl/cnn_img_stream_feeder.sv
// Multi-image stimulus and scoring engine: streams pixel-ROM images into the CNN core,
// tracks in-flight labels in a tag FIFO and scores the returned decisions.
module cnn_img_stream_feeder #(
    parameter int PIX_W      = 8,
    parameter int LABEL_W    = 4,
    parameter int IMG_PIXELS = 784,
    parameter int NUM_IMAGES = 1000,
    parameter int GAP_CYCLES = 1,
    parameter int TAG_DEPTH  = 4,
    parameter int ADDR_W     = 20,
    parameter int IMG_W      = 10,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  pix_addr,
    input  logic [PIX_W-1:0]   pix_rdata,
    output logic [IMG_W-1:0]   lbl_addr,
    input  logic [LABEL_W-1:0] lbl_rdata,
    output logic [PIX_W-1:0]   data_out,
    output logic               valid_out,
    input  logic               cnn_busy,
    input  logic [LABEL_W-1:0] cnn_decision,
    input  logic               cnn_valid,
    output logic [IMG_W:0]     images_sent,
    output logic [IMG_W:0]     results_rcvd,
    output logic [IMG_W:0]     correct_count,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               err_unexpected,
    output logic               done
);

    // state  | meaning
    // IDLE   | after reset, waiting for start
    // WAIT   | next image ready; waiting for !cnn_busy and a free tag slot
    // STREAM | issuing IMG_PIXELS consecutive pixel addresses
    // GAP    | inter-image idle cycles
    // DRAIN  | all images sent; waiting for outstanding decisions
    // DONE   | run complete; results held until the next start

    typedef enum logic [2:0] {
        S_IDLE, S_STREAM, S_GAP, S_WAIT, S_DRAIN, S_DONE
    } state_t;

    localparam int PC_W   = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TAG_AW = $clog2(TAG_DEPTH);

    localparam logic [PC_W-1:0]  PIX_LOAD  = PC_W'(IMG_PIXELS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TAG_AW:0]  TAG_FULL  = (TAG_AW + 1)'(TAG_DEPTH);
    localparam logic [IMG_W:0]   NUM_IMG_C = (IMG_W + 1)'(NUM_IMAGES);

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PC_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [IMG_W:0]     img_q, img_d;
    logic               valid_q, valid_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic [TAG_AW:0]    wr_ptr_q, wr_ptr_d;
    logic [TAG_AW:0]    rd_ptr_q, rd_ptr_d;
    logic [LABEL_W-1:0] tag_mem_q [TAG_DEPTH];
    logic [IMG_W:0]     sent_q, sent_d;
    logic [IMG_W:0]     rcvd_q, rcvd_d;
    logic [IMG_W:0]     correct_q, correct_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic               err_q, err_d;

    logic [TAG_AW:0] tag_cnt;
    logic            tag_empty;
    logic [IMG_W:0]  img_inc;
    logic            run_clear, stream_en, gap_en, count_en, score_en;
    logic            push, pop;

    assign tag_cnt   = wr_ptr_q - rd_ptr_q;
    assign tag_empty = (tag_cnt == '0);
    assign img_inc   = img_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // img_q still holds the current image while in STREAM, and the next one once in GAP
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_WAIT;
            S_WAIT:   if (!cnn_busy && (tag_cnt < TAG_FULL)) state_d = S_STREAM;
            S_STREAM: begin
                if (pix_cnt_q == '0) begin
                    if (GAP_CYCLES > 0)          state_d = S_GAP;
                    else if (img_inc < NUM_IMG_C) state_d = S_WAIT;
                    else                         state_d = S_DRAIN;
                end
            end
            S_GAP:    if (gap_q == '0) state_d = (img_q < NUM_IMG_C) ? S_WAIT : S_DRAIN;
            S_DRAIN:  if (tag_empty && !valid_q && (rcvd_q == NUM_IMG_C)) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run_clear = 1'b0;
        stream_en = 1'b0;
        gap_en    = 1'b0;
        count_en  = 1'b0;
        score_en  = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                score_en  = 1'b0;
                run_clear = start;
            end
            S_DONE: begin
                done      = 1'b1;
                run_clear = start;
            end
            S_STREAM: begin
                stream_en = 1'b1;
                count_en  = 1'b1;
            end
            S_GAP: begin
                gap_en   = 1'b1;
                count_en = 1'b1;
            end
            S_WAIT, S_DRAIN: count_en = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        img_d     = img_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        sent_d    = sent_q;
        rcvd_d    = rcvd_q;
        correct_d = correct_q;
        cycle_d   = cycle_q;
        err_d     = err_q;
        pix_cnt_d = stream_en ? pix_cnt_q - 1'b1 : PIX_LOAD;
        gap_d     = gap_en ? gap_q - 1'b1 : GAP_LOAD;
        valid_d   = stream_en;
        first_d   = stream_en && (pix_cnt_q == PIX_LOAD);
        last_d    = stream_en && (pix_cnt_q == '0);

        // label ROM answers on the same cycle the first pixel reaches the CNN
        push = valid_q && first_q;
        pop  = score_en && cnn_valid && !tag_empty;

        if (stream_en) addr_d = addr_q + 1'b1;
        if (stream_en && (pix_cnt_q == '0)) img_d = img_inc;
        if (valid_q && last_q) sent_d = sent_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rcvd_d   = rcvd_q + 1'b1;
            if (cnn_decision == tag_mem_q[rd_ptr_q[TAG_AW-1:0]]) correct_d = correct_q + 1'b1;
        end
        if (score_en && cnn_valid && tag_empty) err_d = 1'b1;
        if (count_en && (cycle_q != '1)) cycle_d = cycle_q + 1'b1;

        if (run_clear) begin
            addr_d    = '0;
            img_d     = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            sent_d    = '0;
            rcvd_d    = '0;
            correct_d = '0;
            cycle_d   = '0;
            err_d     = 1'b0;
            valid_d   = 1'b0;
            first_d   = 1'b0;
            last_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            pix_cnt_q <= PIX_LOAD;
            gap_q     <= GAP_LOAD;
            img_q     <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            sent_q    <= '0;
            rcvd_q    <= '0;
            correct_q <= '0;
            cycle_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            pix_cnt_q <= pix_cnt_d;
            gap_q     <= gap_d;
            img_q     <= img_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            last_q    <= last_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            sent_q    <= sent_d;
            rcvd_q    <= rcvd_d;
            correct_q <= correct_d;
            cycle_q   <= cycle_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q[TAG_AW-1:0]] <= lbl_rdata;
    end

    assign pix_addr       = addr_q;
    assign lbl_addr       = img_q[IMG_W-1:0];
    assign valid_out      = valid_q;
    assign data_out       = valid_q ? pix_rdata : '0;
    assign images_sent    = sent_q;
    assign results_rcvd   = rcvd_q;
    assign correct_count  = correct_q;
    assign cycle_count    = cycle_q;
    assign err_unexpected = err_q;

endmodule
